// File: rtl/decoder_pipe_if.sv
// Handshake bundle for decoder_pipe: request side (idx/en) and result side (vec/err).
`default_nettype none

interface decoder_pipe_if #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_idx;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_N-1:0] out_vec;
  logic             out_err;

  modport master (
    output in_valid, in_idx, in_en, out_ready,
    input  in_ready, out_valid, out_vec, out_err
  );

  modport slave (
    input  in_valid, in_idx, in_en, out_ready,
    output in_ready, out_valid, out_vec, out_err
  );
endinterface

`default_nettype wire

// File: rtl/decoder_pipe.sv
// +--------------------------------------------------------------------------+
// | decoder_pipe: index decoder (one-hot / thermometer) with 2-entry skid FIFO |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module decoder_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 16,
  parameter int MODE  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_pipe_if.slave  bus
);

  localparam logic [IN_W:0] c_out_n = (IN_W+1)'(OUT_N);

  logic [IN_W:0]    w_idx_ext;
  logic [OUT_N-1:0] w_dec_vec;
  logic             w_dec_err;
  logic             w_push;
  logic             w_pop;

  logic [OUT_N-1:0] r_vec [2];
  logic             r_err [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  // One extra bit so OUT_N == 2**IN_W is representable in the range compare.
  assign w_idx_ext = {1'b0, bus.in_idx};
  assign w_dec_err = bus.in_en & (w_idx_ext >= c_out_n);

  // Out-of-range indices fall out naturally: no one-hot match, every thermometer bit set.
  for (genvar gi = 0; gi < OUT_N; gi++) begin : g_bit
    localparam logic [IN_W:0] c_pos = (IN_W+1)'(gi);
    if (MODE == 0) begin : g_onehot
      assign w_dec_vec[gi] = bus.in_en & (w_idx_ext == c_pos);
    end else begin : g_therm
      assign w_dec_vec[gi] = bus.in_en & (c_pos <= w_idx_ext);
    end
  end

  assign bus.in_ready  = (r_count != 2'd2);
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_vec   = r_vec[r_rd_ptr];
  assign bus.out_err   = r_err[r_rd_ptr];

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec[0] <= '0;
      r_vec[1] <= '0;
      r_err[0] <= 1'b0;
      r_err[1] <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_vec[r_wr_ptr] <= w_dec_vec;
        r_err[r_wr_ptr] <= w_dec_err;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench for decoder_pipe across one-hot and thermometer builds.
`default_nettype none

module tb_decoder_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  decoder_pipe_if #(.IN_W(4), .OUT_N(16)) b0 ();
  decoder_pipe_if #(.IN_W(4), .OUT_N(10)) b1 ();
  decoder_pipe_if #(.IN_W(4), .OUT_N(10)) b2 ();

  decoder_pipe #(.IN_W(4), .OUT_N(16), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  decoder_pipe #(.IN_W(4), .OUT_N(10), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  decoder_pipe #(.IN_W(4), .OUT_N(10), .MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready actual=%b expected=1", b0.in_ready); end
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid actual=%b expected=0", b0.out_valid); end
    checks++; if (b0.out_vec !== 16'h0000) begin failures++; $display("FAIL rst_out_vec actual=%h expected=0000", b0.out_vec); end
    checks++; if (b1.out_err !== 1'b0) begin failures++; $display("FAIL rst_out_err actual=%b expected=0", b1.out_err); end
  endtask

  task automatic test_onehot();
    b0.in_valid = 1'b1; b0.in_idx = 4'd5; b0.in_en = 1'b1; b0.out_ready = 1'b1;
    step();
    checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL onehot_valid actual=%b expected=1", b0.out_valid); end
    checks++; if (b0.out_vec !== 16'h0020) begin failures++; $display("FAIL onehot_vec actual=%h expected=0020", b0.out_vec); end
    checks++; if (b0.out_err !== 1'b0) begin failures++; $display("FAIL onehot_err actual=%b expected=0", b0.out_err); end
    b0.in_valid = 1'b0;
    step();
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL onehot_drain actual=%b expected=0", b0.out_valid); end
  endtask

  task automatic test_modes();
    b1.in_valid = 1'b1; b1.in_idx = 4'd3; b1.in_en = 1'b1; b1.out_ready = 1'b1;
    b2.in_valid = 1'b1; b2.in_idx = 4'd3; b2.in_en = 1'b1; b2.out_ready = 1'b1;
    step();
    checks++; if (b1.out_vec !== 10'h00F) begin failures++; $display("FAIL therm3_vec actual=%h expected=00f", b1.out_vec); end
    checks++; if (b1.out_err !== 1'b0) begin failures++; $display("FAIL therm3_err actual=%b expected=0", b1.out_err); end
    checks++; if (b2.out_vec !== 10'h008) begin failures++; $display("FAIL onehot3_vec actual=%h expected=008", b2.out_vec); end
    b1.in_idx = 4'd12;
    b2.in_idx = 4'd12;
    step();
    checks++; if (b1.out_vec !== 10'h3FF) begin failures++; $display("FAIL therm12_vec actual=%h expected=3ff", b1.out_vec); end
    checks++; if (b1.out_err !== 1'b1) begin failures++; $display("FAIL therm12_err actual=%b expected=1", b1.out_err); end
    checks++; if (b2.out_vec !== 10'h000) begin failures++; $display("FAIL onehot12_vec actual=%h expected=000", b2.out_vec); end
    checks++; if (b2.out_err !== 1'b1) begin failures++; $display("FAIL onehot12_err actual=%b expected=1", b2.out_err); end
    checks++; if (b1.in_ready !== 1'b1) begin failures++; $display("FAIL therm_pass_ready actual=%b expected=1", b1.in_ready); end
    b1.in_valid = 1'b0;
    b2.in_valid = 1'b0;
    step();
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL therm_drain actual=%b expected=0", b1.out_valid); end
    checks++; if (b2.out_valid !== 1'b0) begin failures++; $display("FAIL onehot10_drain actual=%b expected=0", b2.out_valid); end
  endtask

  task automatic test_backpressure();
    b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_en = 1'b1; b0.in_idx = 4'd1;
    step();
    checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_c1 actual=%b expected=1", b0.in_ready); end
    b0.in_idx = 4'd2;
    step();
    checks++; if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full actual=%b expected=0", b0.in_ready); end
    checks++; if (b0.out_vec !== 16'h0002) begin failures++; $display("FAIL bp_head_c2 actual=%h expected=0002", b0.out_vec); end
    b0.in_idx = 4'd3;
    step();
    checks++; if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL bp_held_ready actual=%b expected=0", b0.in_ready); end
    checks++; if (b0.out_vec !== 16'h0002) begin failures++; $display("FAIL bp_stable_vec actual=%h expected=0002", b0.out_vec); end
    checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL bp_stable_valid actual=%b expected=1", b0.out_valid); end
    b0.out_ready = 1'b1;
    step();
    checks++; if (b0.out_vec !== 16'h0004) begin failures++; $display("FAIL bp_second actual=%h expected=0004", b0.out_vec); end
    checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_again actual=%b expected=1", b0.in_ready); end
    step();
    checks++; if (b0.out_vec !== 16'h0008) begin failures++; $display("FAIL bp_third actual=%h expected=0008", b0.out_vec); end
    checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL bp_third_valid actual=%b expected=1", b0.out_valid); end
    b0.in_valid = 1'b0;
    step();
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain actual=%b expected=0", b0.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_vec;
    b0.out_ready = 1'b1; b0.in_valid = 1'b1; b0.in_en = 1'b1; b0.in_idx = 4'd0;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_vec = 16'h0001 << k;
      checks++; if (b0.out_vec !== exp_vec) begin failures++; $display("FAIL stream_vec k=%0d actual=%h expected=%h", k, b0.out_vec, exp_vec); end
      checks++; if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b1) begin failures++; $display("FAIL stream_count k=%0d actual valid=%b ready=%b expected 1/1", k, b0.out_valid, b0.in_ready); end
      if (k == 15) b0.in_valid = 1'b0;
      else b0.in_idx = 4'(k + 1);
    end
    step();
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain actual=%b expected=0", b0.out_valid); end
  endtask

  task automatic test_disable();
    b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_en = 1'b0; b0.in_idx = 4'd7;
    step();
    b0.in_valid = 1'b0; b0.in_en = 1'b1; b0.in_idx = 4'd9;
    checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL dis_valid actual=%b expected=1", b0.out_valid); end
    step();
    checks++; if (b0.out_vec !== 16'h0000) begin failures++; $display("FAIL dis_vec actual=%h expected=0000", b0.out_vec); end
    checks++; if (b0.out_err !== 1'b0) begin failures++; $display("FAIL dis_err actual=%b expected=0", b0.out_err); end
    b0.out_ready = 1'b1;
    step();
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL dis_drain actual=%b expected=0", b0.out_valid); end
  endtask

  task automatic test_reset_midstream();
    b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_en = 1'b1; b0.in_idx = 4'd4;
    step();
    b0.in_idx = 4'd9;
    step();
    b0.in_valid = 1'b0;
    checks++; if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL mid_full actual=%b expected=0", b0.in_ready); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid actual=%b expected=0", b0.out_valid); end
    checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL mid_async_ready actual=%b expected=1", b0.in_ready); end
    checks++; if (b0.out_vec !== 16'h0000) begin failures++; $display("FAIL mid_async_vec actual=%h expected=0000", b0.out_vec); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b0.in_valid = 1'b1; b0.in_idx = 4'd6; b0.out_ready = 1'b1;
    step();
    checks++; if (b0.out_vec !== 16'h0040 || b0.out_valid !== 1'b1) begin failures++; $display("FAIL mid_first_accept actual vec=%h valid=%b expected 0040/1", b0.out_vec, b0.out_valid); end
    b0.in_valid = 1'b0;
    step();
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_stale actual=%b expected=0", b0.out_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    b0.in_valid = 1'b0; b0.in_idx = '0; b0.in_en = 1'b0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_idx = '0; b1.in_en = 1'b0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_idx = '0; b2.in_en = 1'b0; b2.out_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_onehot();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_disable();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter IN_W, default 4, index width in bits, legal range 1..8.
REQ-002 Parameter OUT_N, default 16, output vector width, legal range 1..2**IN_W.
REQ-003 Parameter MODE, default 0, decode mode: 0 = one-hot, 1 = thermometer (bits 0..idx set).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: the upstream request is valid.
REQ-007 Port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 Port in_idx, input, IN_W bits: the index to decode.
REQ-009 Port in_en, input, 1 bit: decode enable; 0 yields an all-zero vector.
REQ-010 Port out_valid, output, 1 bit: the decoded result is valid.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 Port out_vec, output, OUT_N bits: the decoded vector.
REQ-013 Port out_err, output, 1 bit: the index was out of range (in_idx >= OUT_N) with in_en=1.

Function
REQ-014 A transfer in SHALL occur on a rising edge where in_valid=1 and in_ready=1; a transfer out SHALL occur where out_valid=1 and out_ready=1.
REQ-015 The block SHALL hold a 2-entry FIFO (skid buffer) of {vec, err}, with occupancy count 0..2.
REQ-016 in_ready SHALL be 1 exactly when count < 2, derived from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 exactly when count > 0; out_vec and out_err SHALL show the head entry.
REQ-018 Latency SHALL be 1 cycle: a request accepted at edge N with count=0 SHALL appear with out_valid=1 after edge N.
REQ-019 Decode SHALL be computed at accept time and stored, so later in_idx/in_en changes do not alter stored entries.
REQ-020 In MODE 0 with in_en=1 and in_idx < OUT_N, bit in_idx SHALL be 1 and all other bits 0.
REQ-021 In MODE 1 with in_en=1 and in_idx < OUT_N, bits 0..in_idx SHALL be 1 and the rest 0.
REQ-022 With in_en=1 and in_idx >= OUT_N, MODE 0 SHALL store an all-zero vector and MODE 1 an all-ones vector; err SHALL be 1 in both modes.
REQ-023 With in_en=0, the stored entry SHALL be vec = 0 and err = 0 regardless of in_idx.
REQ-024 Simultaneous transfer in and out at count=1 SHALL leave count at 1, with the new entry at the head after the edge.
REQ-025 A transfer out alone SHALL decrement count; a transfer in alone SHALL increment count.
REQ-026 At count=2, in_ready=0; an in_valid=1 in that state SHALL be ignored, with no overwrite and no count change.
REQ-027 While out_valid=1 and out_ready=0, out_vec and out_err SHALL hold stable.
REQ-028 Entries SHALL leave in acceptance order, with none lost or duplicated.
REQ-029 The FIFO pointers SHALL be 1 bit each and wrap 1->0.

Reset
REQ-030 When rst_n=0, count, both pointers, both entries, out_valid, out_vec and out_err SHALL go to 0 immediately, independent of clk.
REQ-031 in_ready SHALL be 1 during and after reset.
REQ-032 Reset asserted mid-stream SHALL discard all buffered entries; no transfer out SHALL occur on the edge where rst_n is released.
REQ-033 Reset release SHALL be synchronous to clk (external synchroniser); the first accept SHALL be possible on the first edge after release.

Verification
REQ-034 IN_W=4, OUT_N=16, MODE 0: send in_idx=5, in_en=1 with out_ready=1 -> one cycle later out_vec=16'h0020, out_err=0, then out_valid=0.
REQ-035 IN_W=4, OUT_N=10, MODE 1: send in_idx=3 -> out_vec=10'h00F; send in_idx=12 -> out_vec=10'h3FF, out_err=1; the same index 12 in MODE 0 -> out_vec=0, out_err=1.
REQ-036 out_ready=0 and send idx 1, 2, 3 back-to-back -> in_ready drops after the second accept, idx 3 is held off, out_vec=16'h0002 stays stable; set out_ready=1 -> outputs 0x0002, 0x0004, 0x0008 in order.
REQ-037 Streaming with in_valid=1 and out_ready=1 every cycle, idx 0..15 -> one result per cycle, count stays 1, output 16'h0001..16'h8000 in order.
REQ-038 Send in_en=0 with in_idx=7 -> out_vec=0, out_err=0.
REQ-039 Fill to count=2, then pulse rst_n=0 between edges -> out_valid=0 and in_ready=1 immediately; after release there is no spurious output.
